// File: rtl/phase_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : phase_seq_pkg                                                |
// | Description : Shared helpers for the phase_seq_first sequencer: the phase  |
// |               width function and the parameter-legality predicate.         |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package phase_seq_pkg;

  // Phase register width. It is never narrower than one bit, so N=1-like
  // corner values still give a legal vector.
  function automatic int phase_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // True when the parameter set describes a realisable sequencer.
  function automatic bit params_legal(input int n, input int target,
                                      input int cnt_w);
    return (n >= 2) && (target >= 0) && (target < n) && (cnt_w >= 1);
  endfunction

endpackage : phase_seq_pkg
`default_nettype wire

// File: rtl/modn_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : modn_counter                                                 |
// | Description : Modulo-N up counter. Advances on inc and wraps exactly from  |
// |               N-1 back to 0, so values >= N are never reached.             |
// | Ports       : clk  - clock, rising edge                                    |
// |               rst  - synchronous active-low reset, clears q to 0           |
// |               inc  - advance enable                                        |
// |               q    - current count [W-1:0]                                 |
// |               wrap - high when the next edge wraps q from N-1 to 0         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module modn_counter #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] C_LAST = W'(N - 1);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic         at_last;

  assign at_last = (q_q == C_LAST);

  always_comb begin
    q_d = q_q;
    if (inc) begin
      q_d = at_last ? '0 : q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign wrap = inc & at_last;

endmodule : modn_counter
`default_nettype wire

// File: rtl/phase_seq_first.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : phase_seq_first                                              |
// | Description : Parametrised modulo-N phase sequencer with a sticky first-   |
// |               arrival flag, per-hit pulse, saturating hit counter,         |
// |               software clear and optional one-shot freeze.                 |
// | Ports       : clk       - clock, rising edge                               |
// |               rst       - synchronous active-low reset                     |
// |               en        - advance enable                                   |
// |               clr_first - synchronous clear of first and hit_cnt           |
// |               phase     - current phase [PW-1:0]                           |
// |               hit       - registered one-cycle pulse on a target hit       |
// |               first     - registered sticky flag, set by any hit           |
// |               hit_cnt   - saturating hit count [CNT_W-1:0]                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module phase_seq_first
  import phase_seq_pkg::*;
#(
  parameter int N       = 3,
  parameter int TARGET  = 2,
  parameter int CNT_W   = 4,
  parameter int ONESHOT = 0,
  localparam int PW     = phase_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_first,
  output logic [PW-1:0]    phase,
  output logic             hit,
  output logic             first,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [PW-1:0]    C_TARGET  = PW'(TARGET);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic             C_ONESHOT = (ONESHOT != 0);

  generate
    if (!params_legal(N, TARGET, CNT_W)) begin : g_bad_params
      $error("phase_seq_first: illegal parameters N=%0d TARGET=%0d CNT_W=%0d",
             N, TARGET, CNT_W);
    end
  endgenerate

  logic             hit_q;
  logic             first_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [PW-1:0]    phase_w_q;
  logic             adv;
  logic             hit_c;
  logic             wrap_unused;

  // In one-shot mode a set first flag freezes the phase until cleared.
  assign adv   = en & ~(C_ONESHOT & first_q);
  assign hit_c = adv & (phase_w_q == C_TARGET);

  modn_counter #(
    .N (N),
    .W (PW)
  ) u_phase (
    .clk  (clk),
    .rst  (rst),
    .inc  (adv),
    .q    (phase_w_q),
    .wrap (wrap_unused)
  );

  // A hit coinciding with a clear counts as the first hit of the new epoch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_first && hit_c) begin
      cnt_d = CNT_W'(1);
    end else if (clr_first) begin
      cnt_d = '0;
    end else if (hit_c && (cnt_q != C_CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q   <= 1'b0;
      first_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hit_q   <= hit_c;
      first_q <= (first_q & ~clr_first) | hit_c;
      cnt_q   <= cnt_d;
    end
  end

  assign phase   = phase_w_q;
  assign hit     = hit_q;
  assign first   = first_q;
  assign hit_cnt = cnt_q;

endmodule : phase_seq_first
`default_nettype wire

// File: tb/tb_phase_seq_first.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_phase_seq_first                                           |
// | Description : Directed self-checking bench for phase_seq_first. Four       |
// |               instances cover the default, stall, saturation and one-shot  |
// |               parameter sets and share one set of drive signals.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_phase_seq_first;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // d0: defaults (N=3, TARGET=2, CNT_W=4)
  logic [1:0] ph0;
  logic       hit0, fst0;
  logic [3:0] cnt0;
  // d1: N=5, TARGET=3
  logic [2:0] ph1;
  logic       hit1, fst1;
  logic [3:0] cnt1;
  // d2: CNT_W=2
  logic [1:0] ph2;
  logic       hit2, fst2;
  logic [1:0] cnt2;
  // d3: ONESHOT, N=4, TARGET=1
  logic [1:0] ph3;
  logic       hit3, fst3;
  logic [3:0] cnt3;

  phase_seq_first u_d0 (
    .clk(clk), .rst(rst), .en(en), .clr_first(clr),
    .phase(ph0), .hit(hit0), .first(fst0), .hit_cnt(cnt0));

  phase_seq_first #(.N(5), .TARGET(3)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .clr_first(clr),
    .phase(ph1), .hit(hit1), .first(fst1), .hit_cnt(cnt1));

  phase_seq_first #(.CNT_W(2)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .clr_first(clr),
    .phase(ph2), .hit(hit2), .first(fst2), .hit_cnt(cnt2));

  phase_seq_first #(.N(4), .TARGET(1), .ONESHOT(1)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .clr_first(clr),
    .phase(ph3), .hit(hit3), .first(fst3), .hit_cnt(cnt3));

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    en  = 1'b0;
    clr = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({ph0, hit0, fst0, cnt0} !== 8'h00) begin
      errors++;
      $display("FAIL reset_d0: got ph=%0d hit=%0b first=%0b cnt=%0d, want all 0",
               ph0, hit0, fst0, cnt0);
    end
    checks++;
    if ({ph1, hit1, fst1, cnt1} !== 9'h000) begin
      errors++;
      $display("FAIL reset_d1: got ph=%0d hit=%0b first=%0b cnt=%0d, want all 0",
               ph1, hit1, fst1, cnt1);
    end
    checks++;
    if ({ph2, hit2, fst2, cnt2} !== 6'h00 || {ph3, hit3, fst3, cnt3} !== 8'h00) begin
      errors++;
      $display("FAIL reset_d2d3: got d2=%0d/%0b/%0b/%0d d3=%0d/%0b/%0b/%0d, want all 0",
               ph2, hit2, fst2, cnt2, ph3, hit3, fst3, cnt3);
    end
  endtask

  task automatic test_legacy();
    apply_reset();
    en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (ph0 !== 2'(k % 3) || hit0 !== ((k % 3) == 0) || fst0 !== (k >= 3) ||
          cnt0 !== 4'(k / 3)) begin
        errors++;
        $display("FAIL legacy k=%0d: got ph=%0d hit=%0b first=%0b cnt=%0d, want ph=%0d hit=%0b first=%0b cnt=%0d",
                 k, ph0, hit0, fst0, cnt0, k % 3, (k % 3) == 0, k >= 3, k / 3);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    en = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (ph1 !== 3'd3 || fst1 !== 1'b0) begin
      errors++;
      $display("FAIL stall_reach: got ph=%0d first=%0b, want ph=3 first=0", ph1, fst1);
    end
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (ph1 !== 3'd3 || hit1 !== 1'b0 || cnt1 !== 4'd0) begin
        errors++;
        $display("FAIL stall_hold k=%0d: got ph=%0d hit=%0b cnt=%0d, want ph=3 hit=0 cnt=0",
                 k, ph1, hit1, cnt1);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (ph1 !== 3'd4 || hit1 !== 1'b1 || fst1 !== 1'b1 || cnt1 !== 4'd1) begin
      errors++;
      $display("FAIL stall_resume: got ph=%0d hit=%0b first=%0b cnt=%0d, want ph=4 hit=1 first=1 cnt=1",
               ph1, hit1, fst1, cnt1);
    end
  endtask

  task automatic test_clear();
    apply_reset();
    en = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (ph0 !== 2'd2 || fst0 !== 1'b1 || cnt0 !== 4'd1) begin
      errors++;
      $display("FAIL clear_setup: got ph=%0d first=%0b cnt=%0d, want ph=2 first=1 cnt=1",
               ph0, fst0, cnt0);
    end
    clr = 1'b1;
    tick();
    checks++;
    if (fst0 !== 1'b1 || cnt0 !== 4'd1 || hit0 !== 1'b1 || ph0 !== 2'd0) begin
      errors++;
      $display("FAIL clear_vs_hit: got ph=%0d hit=%0b first=%0b cnt=%0d, want ph=0 hit=1 first=1 cnt=1",
               ph0, hit0, fst0, cnt0);
    end
    tick();
    clr = 1'b0;
    checks++;
    if (fst0 !== 1'b0 || cnt0 !== 4'd0 || ph0 !== 2'd1) begin
      errors++;
      $display("FAIL clear_only: got ph=%0d first=%0b cnt=%0d, want ph=1 first=0 cnt=0",
               ph0, fst0, cnt0);
    end
    tick(); tick();
    checks++;
    if (fst0 !== 1'b1 || cnt0 !== 4'd1 || hit0 !== 1'b1) begin
      errors++;
      $display("FAIL clear_rehit: got hit=%0b first=%0b cnt=%0d, want hit=1 first=1 cnt=1",
               hit0, fst0, cnt0);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    en = 1'b1;
    for (int p = 1; p <= 6; p++) begin
      tick(); tick(); tick();
      checks++;
      if (cnt2 !== 2'((p > 3) ? 3 : p) || hit2 !== 1'b1) begin
        errors++;
        $display("FAIL saturation p=%0d: got cnt=%0d hit=%0b, want cnt=%0d hit=1",
                 p, cnt2, hit2, (p > 3) ? 3 : p);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [1:0] exp_ph [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    apply_reset();
    en = 1'b1;
    tick();
    tick();
    checks++;
    if (ph3 !== 2'd2 || hit3 !== 1'b1 || fst3 !== 1'b1 || cnt3 !== 4'd1) begin
      errors++;
      $display("FAIL oneshot_hit: got ph=%0d hit=%0b first=%0b cnt=%0d, want ph=2 hit=1 first=1 cnt=1",
               ph3, hit3, fst3, cnt3);
    end
    tick(); tick(); tick();
    checks++;
    if (ph3 !== 2'd2 || hit3 !== 1'b0 || fst3 !== 1'b1 || cnt3 !== 4'd1) begin
      errors++;
      $display("FAIL oneshot_frozen: got ph=%0d hit=%0b first=%0b cnt=%0d, want ph=2 hit=0 first=1 cnt=1",
               ph3, hit3, fst3, cnt3);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (ph3 !== 2'd2 || fst3 !== 1'b0 || cnt3 !== 4'd0) begin
      errors++;
      $display("FAIL oneshot_clear: got ph=%0d first=%0b cnt=%0d, want ph=2 first=0 cnt=0",
               ph3, fst3, cnt3);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (ph3 !== exp_ph[k] || fst3 !== (k == 3) || hit3 !== (k == 3)) begin
        errors++;
        $display("FAIL oneshot_resume k=%0d: got ph=%0d hit=%0b first=%0b, want ph=%0d hit=%0b first=%0b",
                 k, ph3, hit3, fst3, exp_ph[k], k == 3, k == 3);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    en = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    checks++;
    if (ph0 !== 2'd1 || fst0 !== 1'b1 || cnt0 !== 4'd2) begin
      errors++;
      $display("FAIL midrst_setup: got ph=%0d first=%0b cnt=%0d, want ph=1 first=1 cnt=2",
               ph0, fst0, cnt0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({ph0, hit0, fst0, cnt0} !== 8'h00 || {ph3, hit3, fst3, cnt3} !== 8'h00) begin
      errors++;
      $display("FAIL midrst_zero: got d0=%0d/%0b/%0b/%0d d3=%0d/%0b/%0b/%0d, want all 0",
               ph0, hit0, fst0, cnt0, ph3, hit3, fst3, cnt3);
    end
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (ph0 !== 2'(k % 3) || hit0 !== (k == 3) || cnt0 !== 4'(k / 3)) begin
        errors++;
        $display("FAIL midrst_restart k=%0d: got ph=%0d hit=%0b cnt=%0d, want ph=%0d hit=%0b cnt=%0d",
                 k, ph0, hit0, cnt0, k % 3, k == 3, k / 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_stall();
    test_clear();
    test_saturation();
    test_oneshot();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_phase_seq_first
`default_nettype wire
